// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low columns, samples rows per column,
// requires several identical scan frames before a key is reported, and reports it once per press.
module keypad_scanner #(
    parameter int SCAN_CYCLES  = 62501,
    parameter int STABLE_SCANS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [3:0] CODE_NONE = 4'd14;

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} result_t;
    typedef enum logic {ARMED, HELD} state_t;

    logic [3:0]    row_meta_reg, row_sync_reg;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    col_reg;
    logic [3:0]    col_out_reg;
    logic [1:0]    acc_lows_reg;
    logic [3:0]    acc_code_reg;
    result_t       prev_res_reg;
    logic [3:0]    prev_code_reg;
    logic [3:0]    stab_cnt_reg;
    state_t        state_reg, state_next;
    logic [3:0]    key_code_reg;
    logic          key_valid_reg;

    logic          tc, frame_done;
    logic [3:0]    row_low;
    logic [2:0]    col_lows;
    logic [1:0]    col_row;
    logic [3:0]    col_code;
    logic [2:0]    tot_lows;
    logic [3:0]    frame_code;
    result_t       res;
    logic [3:0]    res_code;
    logic [3:0]    stab_next;
    logic          report;

    // Keypad legend indexed by {column, row}, both zero-based; C and D decode as none.
    function automatic logic [3:0] decode(input logic [1:0] col, input logic [1:0] row);
        case ({col, row})
            4'd0:    decode = 4'd1;
            4'd1:    decode = 4'd4;
            4'd2:    decode = 4'd7;
            4'd3:    decode = 4'd10;
            4'd4:    decode = 4'd2;
            4'd5:    decode = 4'd5;
            4'd6:    decode = 4'd8;
            4'd7:    decode = 4'd0;
            4'd8:    decode = 4'd3;
            4'd9:    decode = 4'd6;
            4'd10:   decode = 4'd9;
            4'd11:   decode = 4'd11;
            4'd12:   decode = 4'd12;
            4'd13:   decode = 4'd13;
            default: decode = CODE_NONE;
        endcase
    endfunction

    // row_low[0] is row 1, which arrives on row_in[3].
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign row_low[gi] = ~row_sync_reg[3-gi];
    end

    assign tc         = (cnt_reg == CW'(SCAN_CYCLES - 1));
    assign frame_done = tc && (col_reg == 2'd3);

    always_comb begin
        col_lows = 3'd0;
        col_row  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            col_lows = col_lows + {2'b00, row_low[r]};
            if (row_low[r]) col_row = 2'(r);
        end
        col_code   = decode(col_reg, col_row);
        tot_lows   = {1'b0, acc_lows_reg} + col_lows;
        frame_code = (acc_lows_reg == 2'd0) ? col_code : acc_code_reg;
        if (tot_lows == 3'd0) begin
            res      = RES_NONE;
            res_code = CODE_NONE;
        end else if (tot_lows == 3'd1 && frame_code != CODE_NONE) begin
            res      = RES_KEY;
            res_code = frame_code;
        end else begin
            res      = RES_MULTI;
            res_code = CODE_NONE;
        end
        if (res == prev_res_reg && res_code == prev_code_reg)
            stab_next = (stab_cnt_reg == 4'd15) ? 4'd15 : stab_cnt_reg + 4'd1;
        else
            stab_next = 4'd1;
    end

    always_comb begin
        state_next = state_reg;
        report     = 1'b0;
        if (frame_done) begin
            case (state_reg)
                ARMED: if (res == RES_KEY && stab_next >= 4'(STABLE_SCANS)) begin
                    report     = 1'b1;
                    state_next = HELD;
                end
                HELD: if (res == RES_NONE) state_next = ARMED;
                default: state_next = ARMED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_reg  <= 4'b1111;
            row_sync_reg  <= 4'b1111;
            cnt_reg       <= '0;
            col_reg       <= 2'd0;
            col_out_reg   <= 4'b0111;
            acc_lows_reg  <= 2'd0;
            acc_code_reg  <= CODE_NONE;
            prev_res_reg  <= RES_NONE;
            prev_code_reg <= CODE_NONE;
            stab_cnt_reg  <= 4'd0;
            state_reg     <= ARMED;
            key_code_reg  <= CODE_NONE;
            key_valid_reg <= 1'b0;
        end else begin
            row_meta_reg  <= row_in;
            row_sync_reg  <= row_meta_reg;
            state_reg     <= state_next;
            key_valid_reg <= report;
            if (report) key_code_reg <= res_code;
            if (tc) begin
                cnt_reg     <= '0;
                col_reg     <= col_reg + 2'd1;
                col_out_reg <= {col_out_reg[0], col_out_reg[3:1]};
                if (col_reg == 2'd3) begin
                    acc_lows_reg  <= 2'd0;
                    acc_code_reg  <= CODE_NONE;
                    prev_res_reg  <= res;
                    prev_code_reg <= res_code;
                    stab_cnt_reg  <= stab_next;
                end else begin
                    // Two or more lows is all the frame decision needs to know.
                    acc_lows_reg <= (tot_lows >= 3'd2) ? 2'd2 : tot_lows[1:0];
                    acc_code_reg <= frame_code;
                end
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign col_out   = col_out_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = (state_reg == HELD);

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 matrix keypad and turns it into debounced, one-shot key events. It drives the active-low column outputs and samples the active-low row inputs. It filters bounce over whole scan frames and emits one `key_valid` pulse with a 4-bit key code per physical press. It sits between the keypad pins in `top` and the keypad input buffer that assembles digits, backspace and enter for the CPU I/O path.

## Interface
- SCAN_CYCLES, 62501: clock cycles each column is driven (625.01 µs at 100 MHz); minimum 4.
- STABLE_SCANS, 2: consecutive identical frames required before a key is reported; range 1–15.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; asynchronous and active-high.
- row_in  input  4  keypad rows, active low; row_in[3] = row 1, row_in[0] = row 4.
- col_out  output  4  column drive, one-hot active low. Col 1 = 4'b0111, col 2 = 4'b1011, col 3 = 4'b1101, col 4 = 4'b1110.
- key_code  output  4  last reported key; holds until the next report.
- key_valid  output  1  one-cycle strobe; key_code is valid in the same cycle.
- key_held  output  1  high from the report until the key is released.

## Operation
- Key codes are 0–9 for digits, 10 = `*` backspace, 11 = `#` enter, 12 = `A` pause, 13 = `B` switch, 14 = none.
- Matrix mapping, listed as column: row1/row2/row3/row4.
  - Col 1: 1 / 4 / 7 / 10.
  - Col 2: 2 / 5 / 8 / 0.
  - Col 3: 3 / 6 / 9 / 11.
  - Col 4: 12 / 13 / C / D.
- C and D (col 4, rows 3 and 4) decode as none.
- row_in passes through a 2-flop synchronizer before any use.
- Column counter: a cycle counter runs 0..SCAN_CYCLES-1. When it reaches the terminal count, the column index advances 1→2→3→4→1.
- Row sampling: the synchronized rows are sampled on the terminal-count cycle of each column, which gives the lines settling time.
- Frame: one pass over columns 1–4. Per frame, a decoder accumulates a result.
  - NONE: no row low in any column.
  - KEY(k): exactly one row low in exactly one column; k is the decoded code.
  - MULTI: two or more lows anywhere in the frame, or one low on C or D.
- The frame result is evaluated on the terminal-count cycle of column 4.
- Stability tracking: keep the previous frame result and a saturating count of consecutive equal results.
  - The count resets to 1 on a change.
- FSM with two states:
  - ARMED (reset state): on a frame result KEY(k) with count ≥ STABLE_SCANS:
    - latch key_code = k;
    - pulse key_valid;
    - go to HELD.
  - HELD: key_held = 1. A frame result NONE returns the FSM to ARMED.
    - KEY results, including a different key, and MULTI results are ignored.
    - No second report occurs until a NONE frame has been seen.
- MULTI never reports and never releases; it only breaks stability.
- Reset values:
  - col_out = 4'b0111, with the column index at col 1 and the cycle counter at 0;
  - key_code = 4'd14;
  - key_valid = 0, key_held = 0;
  - state = ARMED, stability count = 0, previous result = NONE;
  - synchronizer flops = 4'b1111.

## Timing
- col_out is registered and changes on the clock edge after the terminal count. Each column is driven for exactly SCAN_CYCLES cycles; one frame = 4·SCAN_CYCLES cycles.
- The synchronizer adds 2 cycles of input latency. A row change must be present at least 3 cycles before a column's terminal count to be captured in that column.
- key_valid rises on the edge after the column-4 terminal count of the STABLE_SCANS-th matching frame. It is high for exactly one cycle, and key_held rises on the same edge.
- key_held falls on the edge after the column-4 terminal count of the first NONE frame.
- Worst-case press-to-report latency is (STABLE_SCANS+1) frames + 3 cycles.
- key_valid is never asserted in two consecutive cycles, and at most once per frame.
- Reset asserted mid-frame acts immediately and asynchronously. The block restarts at col 1 and forgets any stability history; a key held through reset is reported again after STABLE_SCANS frames.
- The cycle counter wraps from SCAN_CYCLES-1 to 0, and the column index wraps from 4 to 1.

## Test plan
Run all scenarios with SCAN_CYCLES = 8 and STABLE_SCANS = 2.
- Column walk: release reset, no key pressed → col_out cycles 0111, 1011, 1101, 1110 every 8 cycles, key_valid never asserts, key_code = 14.
- Single key: hold the "5" pattern (rows 1011 during col 2) for 2 frames, then none for 1 frame. Required:
  - exactly one key_valid, with key_code = 5;
  - key_held high until the edge after the first NONE frame ends.
- Full map: press each of 0–9, `*`, `#`, `A`, `B` separated by one idle frame, matching the bench's keypad function → codes 0–13 are reported in order, one pulse each.
- Bounce: alternate "3" and none on every frame for 6 frames, then hold "3" for 2 frames → no report during the alternation, exactly one report of 3 afterwards.
- Rollover and multi-key:
  - hold "1", then switch to "9" without a NONE frame → only 1 is reported;
  - "1" and "9" low in the same frame → MULTI, no report;
  - C alone → no report.
- Reset mid-press: assert rst for 1 cycle while "7" is held and already reported → outputs return to their reset values at once, then 7 is reported again 2 frames after reset.
